div_unit: RTL

- Multi-cycle integer divider in the EX stage of the MIPS pipeline.
- Consumes the 8-bit ALU control code produced in decode and carried into EX; acts on `EXE_DIV_OP` (signed) and `EXE_DIVU_OP` (unsigned).
- Runs a radix-2 restoring division and stalls the pipeline until the result is ready.
- Returns {hi=remainder, lo=quotient} for the HI/LO write path.

---
 rtl/div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage. Holds the pipeline via div_stall
// while iterating and presents {remainder, quotient} for the HI/LO write path.
module div_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [7:0]  EXE_DIV_OP  = 8'b0001_1010,
  parameter logic [7:0]  EXE_DIVU_OP = 8'b0001_1011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            alucontrolE,
  input  logic [DATA_W-1:0]     srcaE,
  input  logic [DATA_W-1:0]     srcbE,
  input  logic                  flushE,
  input  logic                  ext_stall,
  output logic                  div_stall,
  output logic                  div_valid,
  output logic [2*DATA_W-1:0]   div_result
);

  localparam int unsigned      CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StZero, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic [DATA_W:0]       rem_q, rem_d;
  logic                  neg_q_q, neg_q_d;
  logic                  neg_r_q, neg_r_d;
  logic [2*DATA_W-1:0]   res_q, res_d;

  logic                  is_div, is_divu, start;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic [DATA_W:0]       shifted, trial, rem_next;
  logic                  qbit;
  logic [DATA_W-1:0]     quo_next, quo_fix, rem_fix;

  // Operand decode, absolute values and one restoring-division step.
  always_comb begin
    is_div   = (alucontrolE == EXE_DIV_OP);
    is_divu  = (alucontrolE == EXE_DIVU_OP);
    start    = (state_q == StIdle) && (is_div || is_divu) && !flushE;
    // The most negative value negates to itself, which reads correctly as unsigned.
    abs_a    = (is_div && srcaE[DATA_W-1]) ? (DATA_W'(0) - srcaE) : srcaE;
    abs_b    = (is_div && srcbE[DATA_W-1]) ? (DATA_W'(0) - srcbE) : srcbE;
    shifted  = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    trial    = shifted - {1'b0, dvs_q};
    qbit     = ~trial[DATA_W];
    rem_next = qbit ? trial : shifted;
    quo_next = {dvd_q[DATA_W-2:0], qbit};
    quo_fix  = neg_q_q ? (DATA_W'(0) - quo_next) : quo_next;
    rem_fix  = neg_r_q ? (DATA_W'(0) - rem_next[DATA_W-1:0]) : rem_next[DATA_W-1:0];
  end

  // Next-state logic for the divider FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvs_d   = abs_b;
          neg_q_d = is_div && (srcaE[DATA_W-1] ^ srcbE[DATA_W-1]);
          neg_r_d = is_div && srcaE[DATA_W-1];
          rem_d   = '0;
          cnt_d   = '0;
          if (srcbE == '0) begin
            // Divide-by-zero reports the raw dividend in HI.
            dvd_d   = srcaE;
            state_d = StZero;
          end else begin
            dvd_d   = abs_a;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flushE) begin
          state_d = StIdle;
        end else begin
          dvd_d = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            res_d   = {rem_fix, quo_fix};
            state_d = StDone;
          end
        end
      end
      StZero: begin
        if (flushE) begin
          state_d = StIdle;
        end else begin
          res_d   = {dvd_q, {DATA_W{1'b1}}};
          state_d = StDone;
        end
      end
      StDone: begin
        // Hold the result while EX is frozen so the same instruction does not restart.
        if (flushE || !ext_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      res_q   <= res_d;
    end
  end

  // Stall is combinational so the start cycle itself already holds the pipeline.
  always_comb begin
    div_stall  = !rst && (start || (state_q == StBusy) || (state_q == StZero));
    div_valid  = (state_q == StDone);
    div_result = res_q;
  end

endmodule
